// File: rtl/mem_stall_responder.sv
// Multi-cycle memory responder: one request in flight, registered stall/done.
// Optional MEM_ALIGN_CHECK_EN rejects requests with addr[0]=1.
module mem_stall_responder #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic [15:0] data_in,
  input  logic        rd,
  input  logic        wr,
  output logic        stall,
  output logic        done,
  output logic [15:0] data_out,
  output logic        err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t state, state_n;

  logic [3:0]            count;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic [15:0]           wdata_q;
  logic                  wr_q;
  logic [15:0]           mem [DEPTH];

  logic [DEPTH_LOG2-1:0] idx_in;
  logic [DEPTH_LOG2-1:0] rd_idx;
  logic                  bad_req;
  logic                  ok_req;
  logic                  accept;
  logic                  err_n;
  logic                  load_rd;
  logic                  unused_addr_bits;

  assign idx_in = addr[DEPTH_LOG2:1];
  assign unused_addr_bits = ^{addr[15:DEPTH_LOG2+1], addr[0]};

`ifdef MEM_ALIGN_CHECK_EN
  assign bad_req = (rd & wr) | (addr[0] & (rd | wr));
`else
  assign bad_req = rd & wr;
`endif
  assign ok_req = (rd ^ wr) & ~bad_req;

  assign stall = (state == BUSY);
  assign done  = (state == DONE);

  // Next-state, accept and error decode
  always_comb begin
    state_n = state;
    accept  = 1'b0;
    err_n   = 1'b0;
    unique case (state)
      IDLE: begin
        if (bad_req) begin
          err_n = 1'b1;
        end else if (ok_req) begin
          accept  = 1'b1;
          state_n = (LATENCY == 1) ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (count == 4'd1) state_n = DONE;
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Read data is captured on entry to DONE so it is valid with done
  assign rd_idx  = accept ? idx_in : idx_q;
  assign load_rd = (state_n == DONE) && (state != DONE) &&
                   (accept ? rd : ~wr_q);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  // Latched request, latency counter, read data and error pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count    <= 4'd0;
      idx_q    <= '0;
      wdata_q  <= 16'h0000;
      wr_q     <= 1'b0;
      data_out <= 16'h0000;
      err      <= 1'b0;
    end else begin
      err <= err_n;
      if (accept) begin
        count   <= LAT_M1;
        idx_q   <= idx_in;
        wdata_q <= data_in;
        wr_q    <= wr;
      end else if (state == BUSY) begin
        count <= count - 4'd1;
      end
      if (load_rd) data_out <= mem[rd_idx];
    end
  end

  // Write commits on the edge that leaves DONE; reset forces IDLE first
  always_ff @(posedge clk) begin
    if (state == DONE && wr_q) mem[idx_q] <= wdata_q;
  end

endmodule

// File: tb/tb_mem_stall_responder.sv
// Randomized bench for mem_stall_responder against a transaction model.
// Honours MEM_ALIGN_CHECK_EN the same way as the design.
module tb_mem_stall_responder;

  localparam int L  = 4;
  localparam int DL = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr, data_in, data_out;
  logic        rd, wr, stall, done, err;

  int n_cmp = 0;
  int n_bad = 0;

  mem_stall_responder #(.DEPTH_LOG2(DL), .LATENCY(L)) dut (
    .clk(clk), .rst(rst), .addr(addr), .data_in(data_in),
    .rd(rd), .wr(wr), .stall(stall), .done(done),
    .data_out(data_out), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit misaligned(input logic [15:0] a);
`ifdef MEM_ALIGN_CHECK_EN
    return a[0];
`else
    return 1'b0;
`endif
  endfunction

  // Transaction model: m_t counts cycles since the accept edge
  logic [15:0] m_mem [1024];
  bit          m_busy;
  int          m_t;
  bit          m_wr;
  int          m_idx;
  logic [15:0] m_data;
  logic [15:0] m_exp_data;
  bit          m_err;

  initial for (int i = 0; i < 1024; i++) m_mem[i] = 16'h0000;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy = 0; m_t = 0; m_err = 0; m_exp_data = 16'h0000;
    end else begin
      m_err = 0;
      if (m_busy) begin
        if (m_t == L) begin
          if (m_wr) m_mem[m_idx] = m_data;
          m_busy = 0; m_t = 0;
        end else begin
          m_t++;
          if (m_t == L && !m_wr) m_exp_data = m_mem[m_idx];
        end
      end else if (rd || wr) begin
        if ((rd && wr) || misaligned(addr)) begin
          m_err = 1;
        end else begin
          m_busy = 1; m_t = 1; m_wr = wr;
          m_idx = (int'(addr) >> 1) % (1 << DL);
          m_data = data_in;
          if (L == 1 && !m_wr) m_exp_data = m_mem[m_idx];
        end
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    chk("stall", {31'd0, stall}, {31'd0, m_busy && m_t < L});
    chk("done", {31'd0, done}, {31'd0, m_busy && m_t == L});
    chk("err", {31'd0, err}, {31'd0, m_err});
    chk("data_out", {16'd0, data_out}, {16'd0, m_exp_data});
  end

  // Issue a one-cycle request and watch for done/err within a window
  task automatic op(input logic r, input logic w, input logic [15:0] a,
                    input logic [15:0] d, output int lat,
                    output logic [15:0] q, output bit gd, output bit ge);
    rd = r; wr = w; addr = a; data_in = d;
    @(posedge clk); #1;
    rd = 0; wr = 0;
    lat = 0; q = 16'h0000; gd = 0; ge = 0;
    for (int i = 1; i <= L + 2; i++) begin
      @(negedge clk);
      if (err) ge = 1;
      if (done && !gd) begin gd = 1; lat = i; q = data_out; end
      @(posedge clk); #1;
      if (gd) break;
    end
  endtask

  int          lat;
  logic [15:0] q;
  bit          gd, ge;

  initial begin
    rst = 0; rd = 0; wr = 0; addr = 0; data_in = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_stall", {31'd0, stall}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_data", {16'd0, data_out}, 0);
    rst = 1;
    @(posedge clk); #1;

    // Reset during BUSY drops the write
    wr = 1; addr = 16'h0010; data_in = 16'h1111;
    @(posedge clk); #1;
    wr = 0;
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    chk("midrst_nodone", {31'd0, done}, 0);
    chk("midrst_stall", {31'd0, stall}, 0);
    rst = 1;
    @(posedge clk); #1;
    op(1, 0, 16'h0010, 16'h0, lat, q, gd, ge);
    chk("midrst_rd_done", {31'd0, gd}, 1);
    chk("midrst_rd_data", {16'd0, q}, 32'h0000);

    // Write then read with fixed latency
    op(0, 1, 16'h0010, 16'hBEEF, lat, q, gd, ge);
    chk("wr_lat", lat, 4);
    op(1, 0, 16'h0010, 16'h0, lat, q, gd, ge);
    chk("rd_lat", lat, 4);
    chk("rd_data", {16'd0, q}, 32'hBEEF);

    // Inputs changing during BUSY are ignored
    rd = 1; addr = 16'h0002;
    @(posedge clk); #1;
    rd = 0; wr = 1; addr = 16'h0004; data_in = 16'hDEAD;
    @(posedge clk); #1;
    @(posedge clk); #1;
    wr = 0;
    repeat (3) @(posedge clk);
    #1;
    op(1, 0, 16'h0004, 16'h0, lat, q, gd, ge);
    chk("ignore_data", {16'd0, q}, 32'h0000);

    // Illegal rd&wr
    op(1, 1, 16'h0010, 16'h0, lat, q, gd, ge);
    chk("illegal_err", {31'd0, ge}, 1);
    chk("illegal_nodone", {31'd0, gd}, 0);

    // Address wrap above the depth
    op(0, 1, 16'h0802, 16'h1234, lat, q, gd, ge);
    op(1, 0, 16'h0002, 16'h0, lat, q, gd, ge);
    chk("wrap_data", {16'd0, q}, 32'h1234);

    // Odd address
    op(1, 0, 16'h0003, 16'h0, lat, q, gd, ge);
`ifdef MEM_ALIGN_CHECK_EN
    chk("align_err", {31'd0, ge}, 1);
    chk("align_nodone", {31'd0, gd}, 0);
`else
    chk("align_noerr", {31'd0, ge}, 0);
    chk("align_data", {16'd0, q}, 32'h1234);
`endif

    // Random traffic
    for (int n = 0; n < 200; n++) begin
      int k;
      logic [15:0] a;
      k = $urandom_range(0, 9);
      a = 16'($urandom_range(0, 31) << 11) |
          16'($urandom_range(0, 15) << 1) |
          16'($urandom_range(0, 7) == 0);
      if (k < 4)
        op(1, 0, a, 16'h0, lat, q, gd, ge);
      else if (k < 9)
        op(0, 1, a, 16'($urandom), lat, q, gd, ge);
      else
        op(1, 1, a, 16'h0, lat, q, gd, ge);
      if (gd) chk("rand_lat", lat, L);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    @(posedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
